alu_operand_fetch: RTL
======================

// Module: alu_operand_fetch
// PURPOSE
//  Operand-fetch / writeback stage directly upstream of the 6-bit ALU (reg_opperator).
//  Holds a small register file and accepts one instruction at a time over a valid/ready handshake.
//  Reads two source registers and drives the ALU's instruction/A/B inputs.
//  Captures the ALU result X and writes it back to the destination register.
// PARAMETERS
//  WIDTH  6  data width of registers, ALU operands and result
//  OPW    4  opcode width passed to the ALU instruction port
//  AW     2  register address width (2**AW registers)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  instr_valid  in   1      instruction offered
//  instr_ready  out  1      block can accept an instruction
//  instr_op     in   OPW    opcode forwarded to the ALU
//  instr_rd     in   AW     destination register
//  instr_ra     in   AW     source register for ALU A
//  instr_rb     in   AW     source register for ALU B
//  ld_en        in   1      direct register load strobe
//  ld_addr      in   AW     direct load address
//  ld_data      in   WIDTH  direct load data
//  alu_op       out  OPW    to ALU instruction (registered)
//  alu_a        out  WIDTH  to ALU A (registered)
//  alu_b        out  WIDTH  to ALU B (registered)
//  alu_x        in   WIDTH  from ALU X (combinational path through the ALU)
//  result       out  WIDTH  last captured ALU result
//  done         out  1      one-cycle pulse: result valid, writeback this cycle
// BEHAVIOUR
//  Reset (rst=1 at an edge), all mid-operation state discarded, no writeback performed:
//   - state=IDLE; all registers=0
//   - alu_op/alu_a/alu_b/result=0; done=0
//   - instr_ready=0 while rst high
//  FSM IDLE -> READ -> EXEC -> WB -> IDLE; one instruction in flight.
//   - IDLE: instr_ready=1. If instr_valid, latch op/rd/ra/rb and go to READ. Otherwise stay.
//   - READ: at the edge leaving READ, alu_op<=op, alu_a<=reg[ra], alu_b<=reg[rb].
//   - EXEC: ALU settles. At the edge leaving EXEC, result<=alu_x.
//   - WB: done=1 (combinational from state). At the edge leaving WB, reg[rd]<=result.
//  Timing and ready:
//   - instr_ready=0 in READ, EXEC and WB.
//   - Latency: accept edge E0; done high in the cycle after E2; register updated at E3.
//   - Back-to-back: next accept no earlier than E3 (IDLE). Its READ sees the new value; no bypass needed.
//  Register reads/writes:
//   - ra==rb is legal; both operands get the same value.
//   - Reads sample pre-edge values; a write at the same edge is not visible to that read.
//  Direct load:
//   - ld_en writes reg[ld_addr]<=ld_data at any state edge.
//   - ld_en and WB writeback to the same address at the same edge: WB wins.
//   - Different addresses at the same edge: both writes occur.
//  Width rules:
//   - result is alu_x exactly, WIDTH bits, no extension.
//   - Addresses wrap naturally modulo 2**AW.
//  Holding behaviour:
//   - alu_op/alu_a/alu_b hold their values until the next READ.
//   - result holds until the next EXEC.
// TESTING
//  Bench ALU model: alu_x = alu_a ^ alu_b. alu_op checked for pass-through.
//  1) Reset, then reg dump via ops -> all regs 0; result=0; done never high; instr_ready=1 after rst drop.
//  2) Load r1=6'b001101, r2=6'b010110; issue op=4'b0001 rd=3 ra=1 rb=2:
//     -> alu_op=0001, alu_a=001101, alu_b=010110 two cycles after accept;
//     -> done one cycle later with result=011011; r3=011011.
//  3) Load r0=6'b111111; issue rd=0 ra=0 rb=0 -> result=000000; r0 becomes 0.
//     Then issue rd=1 ra=0 rb=2 immediately -> alu_a=000000.
//  4) During WB of rd=2, assert ld_en ld_addr=2 ld_data=6'b000111 -> r2 holds the WB value.
//     Repeat with ld_addr=1 -> both writes land.
//  5) Assert rst during EXEC -> next cycle state IDLE, done stays 0, destination register 0,
//     instr_ready=1 after rst drops.
//  6) Hold instr_valid high continuously with 3 instructions -> exactly 3 done pulses.
//     Each pulse is 4 cycles apart; instr_ready is low outside IDLE.

Source files
------------

// File: rtl/alu_operand_fetch.sv
// Operand-fetch / writeback stage feeding the 6-bit ALU.
// Runs one instruction at a time through IDLE -> READ -> EXEC -> WB and writes the ALU result back.
module alu_operand_fetch #(
    parameter int WIDTH = 6,
    parameter int OPW   = 4,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [OPW-1:0]   instr_op_i,
    input  logic [AW-1:0]    instr_rd_i,
    input  logic [AW-1:0]    instr_ra_i,
    input  logic [AW-1:0]    instr_rb_i,
    input  logic             ld_en_i,
    input  logic [AW-1:0]    ld_addr_i,
    input  logic [WIDTH-1:0] ld_data_i,
    output logic [OPW-1:0]   alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_x_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_e;

    state_e state_q, state_d;

    logic [OPW-1:0]   op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    ra_q;
    logic [AW-1:0]    rb_q;
    logic [WIDTH-1:0] regs_q [2**AW];
    logic [OPW-1:0]   alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [WIDTH-1:0] result_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid_i) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready_o = (state_q == IDLE) && !rst_i;
        done_o        = (state_q == WB);
    end

    // The writeback is the later assignment, so it overrides a direct load to the same register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            regs_q   <= '{default: '0};
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
        end else begin
            if (state_q == IDLE && instr_valid_i) begin
                op_q <= instr_op_i;
                rd_q <= instr_rd_i;
                ra_q <= instr_ra_i;
                rb_q <= instr_rb_i;
            end
            if (state_q == READ) begin
                alu_op_q <= op_q;
                alu_a_q  <= regs_q[ra_q];
                alu_b_q  <= regs_q[rb_q];
            end
            if (state_q == EXEC) begin
                result_q <= alu_x_i;
            end
            if (ld_en_i) begin
                regs_q[ld_addr_i] <= ld_data_i;
            end
            if (state_q == WB) begin
                regs_q[rd_q] <= result_q;
            end
        end
    end

    assign alu_op_o = alu_op_q;
    assign alu_a_o  = alu_a_q;
    assign alu_b_o  = alu_b_q;
    assign result_o = result_q;

endmodule
